// File: rtl/fnd_scan_monitor.sv
// Recovers the 4-digit hex value from a multiplexed active-low FND anode/segment bus.
// Commit effects appear STABLE_CYCLES+1 edges after a pair is first sampled; no backpressure.
module fnd_scan_monitor #(
   parameter int STABLE_CYCLES  = 4,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic        i_en,
   input  logic [3:0]  i_digit,
   input  logic [7:0]  i_font,
   output logic [15:0] o_value,
   output logic [3:0]  o_dp,
   output logic [3:0]  o_valid,
   output logic [3:0]  o_err,
   output logic        o_update,
   output logic        o_frame
);

   localparam int CW = $clog2(STABLE_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, TRACK, HOLD} state_t;

   state_t          state, state_n;
   logic [CW-1:0]   cnt, cnt_n;
   logic [3:0]      r_digit, p_digit;
   logic [7:0]      r_font, p_font;
   logic [3:0]      seen, seen_set, dig_oh;
   logic [TW-1:0]   tcnt [4];
   logic            sel, same, legal, commit;
   logic [1:0]      dig;
   logic [3:0]      hex;

   // Returns {legal, hex index}; the dp bit is not part of the match.
   function automatic logic [4:0] font_lookup(input logic [6:0] seg);
      case (seg)
         7'h40: return {1'b1, 4'h0};
         7'h79: return {1'b1, 4'h1};
         7'h24: return {1'b1, 4'h2};
         7'h30: return {1'b1, 4'h3};
         7'h19: return {1'b1, 4'h4};
         7'h12: return {1'b1, 4'h5};
         7'h02: return {1'b1, 4'h6};
         7'h78: return {1'b1, 4'h7};
         7'h00: return {1'b1, 4'h8};
         7'h10: return {1'b1, 4'h9};
         7'h08: return {1'b1, 4'hA};
         7'h03: return {1'b1, 4'hB};
         7'h46: return {1'b1, 4'hC};
         7'h21: return {1'b1, 4'hD};
         7'h06: return {1'b1, 4'hE};
         7'h0E: return {1'b1, 4'hF};
         default: return 5'h00;
      endcase
   endfunction

   always_comb begin
      sel = 1'b1;
      dig = 2'd0;
      case (r_digit)
         4'b1110: dig = 2'd0;
         4'b1101: dig = 2'd1;
         4'b1011: dig = 2'd2;
         4'b0111: dig = 2'd3;
         default: sel = 1'b0;
      endcase
      dig_oh       = ~r_digit;
      same         = ({r_digit, r_font} == {p_digit, p_font});
      {legal, hex} = font_lookup(r_font[6:0]);
      seen_set     = seen | dig_oh;
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      commit  = 1'b0;
      if (!i_en) begin
         state_n = IDLE;
         cnt_n   = '0;
      end else begin
         case (state)
            IDLE: begin
               if (sel) begin
                  state_n = TRACK;
                  cnt_n   = CW'(1);
               end
            end
            TRACK: begin
               if (!sel) begin
                  state_n = IDLE;
                  cnt_n   = '0;
               end else if (same) begin
                  cnt_n = cnt + 1'b1;
               end else begin
                  cnt_n = CW'(1);
               end
            end
            HOLD: begin
               if (!sel) begin
                  state_n = IDLE;
                  cnt_n   = '0;
               end else if (!same) begin
                  state_n = TRACK;
                  cnt_n   = CW'(1);
               end
            end
            default: begin
               state_n = IDLE;
               cnt_n   = '0;
            end
         endcase
         // A run reaching the threshold commits once, then parks in HOLD.
         if (state_n == TRACK && cnt_n == CW'(STABLE_CYCLES)) begin
            commit  = 1'b1;
            state_n = HOLD;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_digit  <= 4'hF;
         r_font   <= 8'h00;
         p_digit  <= 4'hF;
         p_font   <= 8'h00;
         o_value  <= '0;
         o_dp     <= '0;
         o_valid  <= '0;
         o_err    <= '0;
         o_update <= 1'b0;
         o_frame  <= 1'b0;
         seen     <= '0;
         for (int k = 0; k < 4; k++) tcnt[k] <= '0;
      end else begin
         r_digit  <= i_digit;
         r_font   <= i_font;
         p_digit  <= r_digit;
         p_font   <= r_font;
         o_update <= commit;
         o_frame  <= 1'b0;
         if (i_en) begin
            for (int k = 0; k < 4; k++) begin
               if (tcnt[k] != TW'(TIMEOUT_CYCLES)) tcnt[k] <= tcnt[k] + 1'b1;
               if (tcnt[k] >= TW'(TIMEOUT_CYCLES - 1)) o_valid[k] <= 1'b0;
            end
         end
         // Placed after the timeout update so a same-cycle commit wins.
         if (commit) begin
            if (legal) begin
               o_value[{dig, 2'b00} +: 4] <= hex;
               o_dp[dig]                  <= ~r_font[7];
               o_valid[dig]               <= 1'b1;
               tcnt[dig]                  <= '0;
               if (seen_set == 4'hF) begin
                  o_frame <= 1'b1;
                  seen    <= '0;
               end else begin
                  seen <= seen_set;
               end
            end else begin
               o_err[dig] <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_fnd_scan_monitor.sv
// Bench for fnd_scan_monitor: directed scenarios plus a randomized scan stream
// checked against a run-length reference model.
module tb_fnd_scan_monitor;

   localparam int STABLE = 4;
   localparam int TMO    = 20;

   logic        i_clk = 1'b0;
   logic        i_reset_n = 1'b0;
   logic        i_en = 1'b1;
   logic [3:0]  i_digit = 4'hF;
   logic [7:0]  i_font = 8'hFF;
   logic [15:0] o_value;
   logic [3:0]  o_dp, o_valid, o_err;
   logic        o_update, o_frame;

   int n_vec = 0;
   int n_err = 0;

   logic [6:0] font_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   // Reference model state: last two sampled pairs and the length of the current run.
   logic [15:0] m_value;
   logic [3:0]  m_dp, m_valid, m_err, m_seen;
   logic        m_upd, m_frm;
   logic [3:0]  pd1, pd2;
   logic [7:0]  pf1, pf2;
   int          run;
   int          age [4];

   fnd_scan_monitor #(.STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(TMO)) dut (
      .i_clk(i_clk), .i_reset_n(i_reset_n), .i_en(i_en),
      .i_digit(i_digit), .i_font(i_font),
      .o_value(o_value), .o_dp(o_dp), .o_valid(o_valid), .o_err(o_err),
      .o_update(o_update), .o_frame(o_frame)
   );

   always #5 i_clk = ~i_clk;

   task automatic model_edge();
      int k;
      int idx;
      logic [3:0] oh;
      if (!i_reset_n) begin
         m_value = '0; m_dp = '0; m_valid = '0; m_err = '0; m_seen = '0;
         m_upd = 1'b0; m_frm = 1'b0; run = 0;
         pd1 = 4'hF; pd2 = 4'hF; pf1 = 8'h00; pf2 = 8'h00;
         for (int j = 0; j < 4; j++) age[j] = 0;
      end else begin
         m_upd = 1'b0;
         m_frm = 1'b0;
         if (i_en) begin
            for (int j = 0; j < 4; j++) begin
               if (age[j] < TMO) age[j]++;
               if (age[j] >= TMO) m_valid[j] = 1'b0;
            end
            k = -1;
            for (int j = 0; j < 4; j++) begin
               oh = 4'b0001 << j;
               if (pd1 == ~oh) k = j;
            end
            if (k < 0) run = 0;
            else if (run > 0 && pd1 == pd2 && pf1 == pf2) begin
               if (run <= STABLE) run++;
            end else run = 1;
            if (k >= 0 && run == STABLE) begin
               m_upd = 1'b1;
               idx = -1;
               for (int i = 0; i < 16; i++) if (font_tab[i] == pf1[6:0]) idx = i;
               if (idx >= 0) begin
                  m_value[4*k +: 4] = 4'(idx);
                  m_dp[k] = ~pf1[7];
                  m_valid[k] = 1'b1;
                  age[k] = 0;
                  m_seen[k] = 1'b1;
                  if (m_seen == 4'hF) begin
                     m_frm = 1'b1;
                     m_seen = '0;
                  end
               end else begin
                  m_err[k] = 1'b1;
               end
            end
         end else begin
            run = 0;
         end
         pd2 = pd1; pf2 = pf1;
         pd1 = i_digit; pf1 = i_font;
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      model_edge();
      #1;
   endtask

   task automatic do_reset();
      i_reset_n = 1'b0;
      tick();
      tick();
      i_reset_n = 1'b1;
   endtask

   task automatic test_reset();
      i_reset_n = 1'b0;
      tick();
      tick();
      n_vec++;
      if ({o_value, o_dp, o_valid, o_err, o_update, o_frame} !== 30'd0) begin
         n_err++;
         $display("FAIL reset: outputs=%h required 0",
                  {o_value, o_dp, o_valid, o_err, o_update, o_frame});
      end
      i_reset_n = 1'b1;
   endtask

   task automatic test_single_digit();
      i_digit = 4'b1110; i_font = 8'hA4;
      for (int e = 1; e <= 6; e++) begin
         tick();
         n_vec++;
         if (o_update !== (e == 5)) begin
            n_err++;
            $display("FAIL single_update edge %0d: got %b required %b", e, o_update, e == 5);
         end
      end
      n_vec++;
      if (o_value[3:0] !== 4'h2 || o_valid !== 4'b0001 || o_dp[0] !== 1'b0) begin
         n_err++;
         $display("FAIL single_result: value=%h valid=%b dp0=%b required 2/0001/0",
                  o_value[3:0], o_valid, o_dp[0]);
      end
   endtask

   task automatic test_scan_frame();
      logic [3:0] digs [4];
      logic [7:0] fnts [4];
      int upd, frm, frm_at;
      digs = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      fnts = '{8'hF9, 8'h99, 8'h88, 8'h0E};
      upd = 0; frm = 0; frm_at = 0;
      for (int p = 0; p <= 4; p++) begin
         i_digit = (p < 4) ? digs[p] : 4'hF;
         i_font  = (p < 4) ? fnts[p] : 8'hFF;
         for (int c = 0; c < 4; c++) begin
            tick();
            if (o_update) upd++;
            if (o_frame) begin
               frm++;
               frm_at = o_update ? upd : -1;
            end
         end
      end
      n_vec++;
      if (o_value !== 16'hFA41 || o_dp !== 4'b1000) begin
         n_err++;
         $display("FAIL scan_value: value=%h dp=%b required FA41/1000", o_value, o_dp);
      end
      n_vec++;
      if (upd != 4 || frm != 1 || frm_at != 4) begin
         n_err++;
         $display("FAIL scan_frame: updates=%0d frames=%0d frame_with=%0d required 4/1/4",
                  upd, frm, frm_at);
      end
   endtask

   task automatic test_glitch();
      int upd;
      do_reset();
      upd = 0;
      i_digit = 4'b1110; i_font = 8'hC0;
      for (int c = 0; c < 3; c++) begin tick(); if (o_update) upd++; end
      i_font = 8'hF9;
      for (int c = 0; c < 4; c++) begin tick(); if (o_update) upd++; end
      i_digit = 4'hF;
      for (int c = 0; c < 2; c++) begin tick(); if (o_update) upd++; end
      n_vec++;
      if (upd != 1 || o_value[3:0] !== 4'h1) begin
         n_err++;
         $display("FAIL glitch: updates=%0d value=%h required 1/1", upd, o_value[3:0]);
      end
   endtask

   task automatic test_illegal();
      int upd;
      logic [15:0] saved;
      saved = o_value;
      upd = 0;
      i_digit = 4'b1101; i_font = 8'hFF;
      for (int c = 0; c < 4; c++) begin tick(); if (o_update) upd++; end
      i_digit = 4'hF;
      tick(); if (o_update) upd++;
      n_vec++;
      if (o_err !== 4'b0010 || upd != 1 || o_value !== saved) begin
         n_err++;
         $display("FAIL illegal_font: err=%b updates=%0d value=%h required 0010/1/%h",
                  o_err, upd, o_value, saved);
      end
      upd = 0;
      i_digit = 4'b1100; i_font = 8'hA4;
      for (int c = 0; c < 6; c++) begin tick(); if (o_update) upd++; end
      i_digit = 4'hF;
      tick(); if (o_update) upd++;
      n_vec++;
      if (upd != 0 || o_err !== 4'b0010) begin
         n_err++;
         $display("FAIL multi_low: updates=%0d err=%b required 0/0010", upd, o_err);
      end
   endtask

   task automatic test_timeout();
      int rise, fall, k;
      logic [27:0] snap;
      do_reset();
      rise = -1; fall = -1;
      i_digit = 4'b1110; i_font = 8'hC0;
      for (int c = 1; c <= 45; c++) begin
         if (c == 5) begin i_digit = 4'b1101; i_font = 8'hF9; end
         tick();
         if (rise < 0 && o_valid[0]) rise = c;
         if (rise >= 0 && fall < 0 && !o_valid[0]) fall = c;
      end
      n_vec++;
      if (rise < 0 || fall < 0 || fall - rise != TMO) begin
         n_err++;
         $display("FAIL timeout_span: rise=%0d fall=%0d required span %0d", rise, fall, TMO);
      end
      i_digit = 4'b1110; i_font = 8'hC0;
      for (int c = 0; c < 4; c++) tick();
      i_digit = 4'b1101; i_font = 8'hF9;
      tick();
      snap = {o_value, o_dp, o_valid, o_err};
      i_en = 1'b0;
      for (int c = 0; c < 30; c++) begin
         i_digit = 4'b1110; i_font = (c < 15) ? 8'hC0 : 8'hA4;
         tick();
         n_vec++;
         if ({o_value, o_dp, o_valid, o_err} !== snap || o_update !== 1'b0 || o_frame !== 1'b0) begin
            n_err++;
            $display("FAIL en_hold cycle %0d: got %h/%b%b required %h/00", c,
                     {o_value, o_dp, o_valid, o_err}, o_update, o_frame, snap);
         end
      end
      i_en = 1'b1;
      i_digit = 4'b1101; i_font = 8'hF9;
      k = -1;
      for (int c = 1; c <= 40; c++) begin
         tick();
         if (k < 0 && !o_valid[0]) k = c;
      end
      n_vec++;
      if (k != TMO) begin
         n_err++;
         $display("FAIL timeout_frozen: fell after %0d enabled edges required %0d", k, TMO);
      end
   endtask

   task automatic test_random();
      int hold;
      logic [29:0] exp_v, got_v;
      hold = 0;
      do_reset();
      for (int c = 0; c < 2000; c++) begin
         if (hold == 0) begin
            case ($urandom_range(0, 9))
               0: i_digit = 4'hF;
               1: i_digit = 4'($urandom_range(0, 15));
               default: i_digit = ~(4'b0001 << $urandom_range(0, 3));
            endcase
            if ($urandom_range(0, 7) == 0) i_font = 8'($urandom_range(0, 255));
            else i_font = {1'($urandom_range(0, 1)), font_tab[$urandom_range(0, 15)]};
            hold = $urandom_range(1, 6);
         end
         hold--;
         if ($urandom_range(0, 29) == 0) i_en = ~i_en;
         i_reset_n = ($urandom_range(0, 249) != 0);
         tick();
         exp_v = {m_value, m_dp, m_valid, m_err, m_upd, m_frm};
         got_v = {o_value, o_dp, o_valid, o_err, o_update, o_frame};
         n_vec++;
         if (got_v !== exp_v) begin
            n_err++;
            $display("FAIL random cycle %0d: got %h required %h", c, got_v, exp_v);
         end
      end
      i_reset_n = 1'b1;
      i_en = 1'b1;
   endtask

   initial begin
      test_reset();
      test_single_digit();
      test_scan_frame();
      test_glitch();
      test_illegal();
      test_timeout();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
